// File: rtl/mmu_bus_sequencer.sv
// Round-robin front end: each channel request gets one MMU translate cycle, then bus access cycles.
// Optional bus watchdog enabled by defining MMU_BUS_TIMEOUT_EN.
`timescale 1ns/1ps

`ifndef MEM_ACCESS
`define MEM_ACCESS 2
`endif
`ifndef MEM_ACCESS_NONE
`define MEM_ACCESS_NONE 2'd0
`endif
`ifndef MEM_ACCESS_R
`define MEM_ACCESS_R 2'd1
`endif
`ifndef MEM_ACCESS_W
`define MEM_ACCESS_W 2'd2
`endif
`ifndef MEM_ACCESS_X
`define MEM_ACCESS_X 2'd3
`endif
`ifndef MEM_LEN
`define MEM_LEN 2
`endif
`ifndef MMU_EXCEPTION
`define MMU_EXCEPTION 2
`endif
`ifndef MMU_EXCEPTION_NONE
`define MMU_EXCEPTION_NONE 2'd0
`endif

module mmu_bus_sequencer #(
    parameter int NCH            = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int GW            = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic [NCH*`MEM_ACCESS-1:0]    ch_access,
    input  logic [NCH*AW-1:0]             ch_addr,
    input  logic [NCH*DW-1:0]             ch_wdata,
    input  logic [NCH*`MEM_LEN-1:0]       ch_len,
    output logic [NCH-1:0]                ch_ready,
    output logic [NCH-1:0]                ch_fault,
    output logic [DW-1:0]                 ch_rdata,
    output logic                          mmu_addr_valid,
    output logic [AW-1:0]                 mmu_vaddr,
    output logic [`MEM_ACCESS-1:0]        mmu_access,
    input  logic [AW-1:0]                 mmu_paddr,
    input  logic [`MMU_EXCEPTION-1:0]     mmu_exception,
    output logic [AW-1:0]                 db_addr,
    output logic [DW-1:0]                 db_dataOut,
    input  logic [DW-1:0]                 db_dataIn,
    input  logic                          db_ready,
    output logic [`MEM_ACCESS-1:0]        db_accessType,
    output logic [`MEM_LEN-1:0]           db_memLen,
    output logic [AW-1:0]                 vAddr,
    output logic [GW-1:0]                 grant_ch,
    output logic                          bus_timeout
);

    typedef enum logic [1:0] {S_IDLE, S_SAVE_ADDR, S_ACCESS_MEM} state_t;

    state_t                   state_reg;
    logic [GW-1:0]            grant_reg;
    logic [GW-1:0]            last_grant_reg;
    logic [AW-1:0]            vaddr_reg;
    logic [`MEM_ACCESS-1:0]   access_reg;
    logic [`MEM_LEN-1:0]      len_reg;
    logic [DW-1:0]            wdata_reg;

    logic [NCH-1:0]           req;
    logic [`MEM_ACCESS-1:0]   acc_arr   [NCH];
    logic [AW-1:0]            addr_arr  [NCH];
    logic [DW-1:0]            wdata_arr [NCH];
    logic [`MEM_LEN-1:0]      len_arr   [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign acc_arr[gi]   = ch_access[gi*`MEM_ACCESS +: `MEM_ACCESS];
            assign addr_arr[gi]  = ch_addr[gi*AW +: AW];
            assign wdata_arr[gi] = ch_wdata[gi*DW +: DW];
            assign len_arr[gi]   = ch_len[gi*`MEM_LEN +: `MEM_LEN];
            assign req[gi]       = (acc_arr[gi] != `MEM_ACCESS_NONE);
        end
    endgenerate

    logic active, exc, timeout_hit, done, take;
    logic win_found;
    logic [GW-1:0] win_idx;

    // On completion the search starts after the finishing channel and skips it.
    always_comb begin
        int base;
        int span;
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        base      = (state_reg == S_ACCESS_MEM) ? int'(grant_reg) : int'(last_grant_reg);
        span      = (state_reg == S_ACCESS_MEM) ? NCH - 1 : NCH;
        idx       = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = base + k;
            if (idx >= NCH)
                idx = idx - NCH;
            if (!win_found && k <= span && req[idx]) begin
                win_found = 1'b1;
                win_idx   = GW'(idx);
            end
        end
    end

    assign active = res && (state_reg == S_ACCESS_MEM);
    assign exc    = (mmu_exception != `MMU_EXCEPTION_NONE);

`ifdef MMU_BUS_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES < 256) ? 8 : 16;
    logic [TW-1:0] tmo_cnt_reg;
    assign timeout_hit = active && !db_ready && (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // A pending exception always wins over db_ready and the watchdog.
    assign done = active && (exc || db_ready || timeout_hit);
    assign take = res && win_found && ((state_reg == S_IDLE) || done);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_resp
            assign ch_ready[gi] = done && (grant_reg == GW'(gi));
            assign ch_fault[gi] = active && (exc || timeout_hit) && (grant_reg == GW'(gi));
        end
    endgenerate

    assign ch_rdata       = (active && db_ready && !exc) ? db_dataIn : '0;
    assign mmu_addr_valid = res && (state_reg == S_SAVE_ADDR);
    assign mmu_vaddr      = vaddr_reg;
    assign mmu_access     = access_reg;
    assign db_addr        = mmu_paddr;
    assign db_dataOut     = wdata_reg;
    assign db_memLen      = len_reg;
    assign db_accessType  = (active && !exc) ? access_reg : `MEM_ACCESS_NONE;
    assign bus_timeout    = timeout_hit && !exc;
    assign vAddr          = vaddr_reg;
    assign grant_ch       = grant_reg;

    always_ff @(posedge clk) begin
        if (!res) begin
            state_reg      <= S_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= GW'(NCH - 1);
            vaddr_reg      <= '0;
            access_reg     <= `MEM_ACCESS_NONE;
            len_reg        <= '0;
            wdata_reg      <= '0;
`ifdef MMU_BUS_TIMEOUT_EN
            tmo_cnt_reg    <= '0;
`endif
        end else begin
            if (take) begin
                grant_reg  <= win_idx;
                vaddr_reg  <= addr_arr[win_idx];
                access_reg <= acc_arr[win_idx];
                len_reg    <= len_arr[win_idx];
                wdata_reg  <= wdata_arr[win_idx];
            end
            case (state_reg)
                S_IDLE: begin
                    if (win_found)
                        state_reg <= S_SAVE_ADDR;
                end
                S_SAVE_ADDR: begin
                    state_reg <= S_ACCESS_MEM;
                end
                S_ACCESS_MEM: begin
                    if (done) begin
                        last_grant_reg <= grant_reg;
                        state_reg      <= win_found ? S_SAVE_ADDR : S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
`ifdef MMU_BUS_TIMEOUT_EN
            if (state_reg == S_SAVE_ADDR)
                tmo_cnt_reg <= '0;
            else if (state_reg == S_ACCESS_MEM && !db_ready)
                tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
`endif
        end
    end

endmodule
